// File: rtl/golden_bist_pkg.sv
// Shared definitions for the golden-model BIST: reference-function mode
// encodings, FSM state encoding and the settle counter width.
package golden_bist_pkg;

  localparam logic [1:0] MODE_OR  = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_NOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    CHECK = 2'b10,
    DONE  = 2'b11
  } state_e;

  // Wide enough for the largest settle time of 255 cycles.
  localparam int CNT_W = 8;

endpackage

// File: rtl/golden_bist_eval.sv
// Combinational reference function applied across every bit of the
// stimulus vector; kept standalone so benches can reuse it.
module golden_eval
  import golden_bist_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] vec,
  input  logic [1:0]   mode,
  output logic         expected
);

  always_comb begin
    expected = 1'b0;
    case (mode)
      MODE_OR:  expected = |vec;
      MODE_AND: expected = &vec;
      MODE_XOR: expected = ^vec;
      MODE_NOR: expected = ~(|vec);
      default:  expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/golden_bist.sv
// Exhaustive BIST sequencer: walks every N-bit vector, lets the DUT settle,
// and compares its response against the golden reference function.
module golden_bist
  import golden_bist_pkg::*;
#(
  parameter int N      = 2,
  parameter int SETTLE = 4
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         start,
  input  logic [1:0]   mode,
  output logic [N-1:0] vec,
  input  logic         resp,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_cnt,
  output logic [N-1:0] first_err_vec,
  output logic         first_err_valid
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]     VEC_ONE     = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]     VEC_LAST    = {N{1'b1}};
  localparam logic [N:0]       ERR_ONE     = {{N{1'b0}}, 1'b1};

  state_e           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       mode_q;
  logic             expected;
  logic             mismatch;

  golden_eval #(.N(N)) u_eval (
    .vec      (vec),
    .mode     (mode_q),
    .expected (expected)
  );

  // resp only feeds flops below, never an output port directly.
  assign mismatch = (resp != expected);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      mode_q          <= MODE_OR;
      vec             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= WAIT;
            wait_cnt        <= '0;
            mode_q          <= mode;
            vec             <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
          end
        end

        WAIT: begin
          wait_cnt <= wait_cnt + CNT_ONE;
          if (wait_cnt == SETTLE_LAST) begin
            state <= CHECK;
          end
        end

        CHECK: begin
          if (mismatch) begin
            err_cnt <= err_cnt + ERR_ONE;
            if (!first_err_valid) begin
              first_err_vec   <= vec;
              first_err_valid <= 1'b1;
            end
          end
          // The last vector's own mismatch must count toward pass.
          if (vec == VEC_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == '0) && !mismatch;
          end else begin
            state    <= WAIT;
            vec      <= vec + VEC_ONE;
            wait_cnt <= '0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
